// File: rtl/bp_sched.sv
// Iteration scheduler for the polar BP min-sum PE array: sweeps stages L then R,
// issues read and delayed write-back addresses, and runs the early-termination handshake.
module bp_sched #(
  parameter int LOG_N    = 6,
  parameter int LOG_P    = 3,
  parameter int MAX_ITER = 15,
  parameter int G_LAT    = 1,
  localparam int G       = 1 << (LOG_N - 1 - LOG_P),
  localparam int GW      = ((LOG_N - 1 - LOG_P) > 1) ? (LOG_N - 1 - LOG_P) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             chk_valid,
  input  logic             chk_pass,
  output logic             busy,
  output logic             done,
  output logic [3:0]       iter,
  output logic             rd_en,
  output logic             dir,
  output logic [LOG_N-1:0] stage,
  output logic [GW-1:0]    grp,
  output logic             wr_en,
  output logic             wr_dir,
  output logic [LOG_N-1:0] wr_stage,
  output logic [GW-1:0]    wr_grp,
  output logic             chk_req
);

  localparam int BW = $clog2(G_LAT + 1);
  localparam int PW = 2 + LOG_N + GW;
  localparam logic [LOG_N-1:0] STAGE_LAST = LOG_N'(LOG_N - 1);
  localparam logic [GW-1:0]    GRP_LAST   = GW'(G - 1);
  localparam logic [3:0]       ITER_LAST  = 4'(MAX_ITER - 1);
  localparam logic [BW-1:0]    BUB_LAST   = BW'(G_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWEEP  = 3'd1,
    S_BUBBLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_r;
  logic [BW-1:0] bub_r;
  logic [PW-1:0] pipe_r [G_LAT];

  // Sweep/check FSM; every output is a register so consumers see glitch-free controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      bub_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      iter    <= 4'd0;
      rd_en   <= 1'b0;
      dir     <= 1'b0;
      stage   <= '0;
      grp     <= '0;
      chk_req <= 1'b0;
    end else if (abort) begin
      state_r <= S_IDLE;
      bub_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      dir     <= 1'b0;
      stage   <= '0;
      grp     <= '0;
      chk_req <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_SWEEP;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            dir     <= 1'b0;
            stage   <= STAGE_LAST;
            grp     <= '0;
            iter    <= 4'd0;
          end
        end
        S_SWEEP: begin
          if (grp == GRP_LAST) begin
            state_r <= S_BUBBLE;
            rd_en   <= 1'b0;
            bub_r   <= '0;
          end else begin
            grp <= grp + GW'(1);
          end
        end
        // The bubble lets the last group of a stage be written back before its neighbour is read.
        S_BUBBLE: begin
          if (bub_r == BUB_LAST) begin
            grp <= '0;
            if (!dir) begin
              state_r <= S_SWEEP;
              rd_en   <= 1'b1;
              if (stage != '0) begin
                stage <= stage - LOG_N'(1);
              end else begin
                dir <= 1'b1;
              end
            end else if (stage != STAGE_LAST) begin
              state_r <= S_SWEEP;
              rd_en   <= 1'b1;
              stage   <= stage + LOG_N'(1);
            end else begin
              state_r <= S_CHECK;
              chk_req <= 1'b1;
            end
          end else begin
            bub_r <= bub_r + BW'(1);
          end
        end
        S_CHECK: begin
          if (chk_valid) begin
            chk_req <= 1'b0;
            if (chk_pass || (iter == ITER_LAST)) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r <= S_SWEEP;
              iter    <= iter + 4'd1;
              rd_en   <= 1'b1;
              dir     <= 1'b0;
              stage   <= STAGE_LAST;
              grp     <= '0;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          rd_en   <= 1'b0;
          chk_req <= 1'b0;
        end
      endcase
    end
  end

  // Write-back address pipeline: free-running, flushed only by reset or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < G_LAT; i++) pipe_r[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < G_LAT; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= {rd_en, dir, stage, grp};
      for (int i = 1; i < G_LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign {wr_en, wr_dir, wr_stage, wr_grp} = pipe_r[G_LAT-1];

endmodule

// File: tb/tb_bp_sched.sv
// Self-checking bench for bp_sched: a per-cycle trace model built from the sweep rules
// drives the check handshake and is compared against two parameterisations of the DUT.
module tb_bp_sched;
  localparam int MAX_ITER = 15;
  localparam logic [26:0] M_CTRL = 27'h61C0000;  // busy, done, rd_en, chk_req, wr_en
  localparam logic [26:0] M_HEAD = 27'h7FC0000;  // busy..wr_en including iter
  localparam logic [26:0] M_RD   = 27'h003FE00;
  localparam logic [26:0] M_WR   = 27'h00001FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   sel = 0;
  logic start_d = 1'b0, abort_d = 1'b0, cv_d = 1'b0, cp_d = 1'b0;
  logic start_a, abort_a, cv_a, start_b, abort_b, cv_b;
  assign start_a = start_d && (sel == 0);
  assign abort_a = abort_d && (sel == 0);
  assign cv_a    = cv_d && (sel == 0);
  assign start_b = start_d && (sel == 1);
  assign abort_b = abort_d && (sel == 1);
  assign cv_b    = cv_d && (sel == 1);

  logic busy_a, done_a, rd_en_a, dir_a, wr_en_a, wr_dir_a, chk_req_a;
  logic [3:0] iter_a;
  logic [5:0] stage_a, wr_stage_a;
  logic [1:0] grp_a, wr_grp_a;
  logic busy_b, done_b, rd_en_b, dir_b, wr_en_b, wr_dir_b, chk_req_b;
  logic [3:0] iter_b;
  logic [5:0] stage_b, wr_stage_b;
  logic [0:0] grp_b, wr_grp_b;

  bp_sched u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .chk_valid(cv_a), .chk_pass(cp_d),
    .busy(busy_a), .done(done_a), .iter(iter_a), .rd_en(rd_en_a), .dir(dir_a), .stage(stage_a),
    .grp(grp_a), .wr_en(wr_en_a), .wr_dir(wr_dir_a), .wr_stage(wr_stage_a), .wr_grp(wr_grp_a),
    .chk_req(chk_req_a)
  );

  bp_sched #(.LOG_P(5), .G_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .chk_valid(cv_b), .chk_pass(cp_d),
    .busy(busy_b), .done(done_b), .iter(iter_b), .rd_en(rd_en_b), .dir(dir_b), .stage(stage_b),
    .grp(grp_b), .wr_en(wr_en_b), .wr_dir(wr_dir_b), .wr_stage(wr_stage_b), .wr_grp(wr_grp_b),
    .chk_req(chk_req_b)
  );

  logic [26:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, iter_a, rd_en_a, chk_req_a, wr_en_a, dir_a, stage_a, grp_a,
                  wr_dir_a, wr_stage_a, wr_grp_a};
  assign obs_b = {busy_b, done_b, iter_b, rd_en_b, chk_req_b, wr_en_b, dir_b, stage_b, 1'b0, grp_b,
                  wr_dir_b, wr_stage_b, 1'b0, wr_grp_b};

  int checks = 0;
  int failures = 0;

  // kind: 0 sweep/bubble, 1 check waiting, 2 check with result, 3 done
  typedef struct {
    bit rd; bit dr; int st; int gp; int it; int kind; bit cp;
  } ent_t;
  ent_t tr[$];

  function automatic void build(int g, int glat, int pass_iter, int maxd);
    int last_it;
    int st;
    int d;
    ent_t e;
    last_it = (pass_iter < MAX_ITER) ? pass_iter : MAX_ITER - 1;
    tr.delete();
    for (int it = 0; it <= last_it; it++) begin
      for (int h = 0; h < 2; h++) begin
        for (int k = 0; k < 6; k++) begin
          st = (h == 1) ? k : 5 - k;
          for (int gp = 0; gp < g; gp++) begin
            e = '{1'b1, h[0], st, gp, it, 0, 1'b0};
            tr.push_back(e);
          end
          for (int b = 0; b < glat; b++) begin
            e = '{1'b0, h[0], st, 0, it, 0, 1'b0};
            tr.push_back(e);
          end
        end
      end
      d = int'($urandom_range(maxd, 0));
      for (int j = 0; j < d; j++) begin
        e = '{1'b0, 1'b1, 5, 0, it, 1, 1'b0};
        tr.push_back(e);
      end
      e = '{1'b0, 1'b1, 5, 0, it, 2, (it == pass_iter)};
      tr.push_back(e);
    end
    e = '{1'b0, 1'b1, 5, 0, last_it, 3, 1'b0};
    tr.push_back(e);
  endfunction

  function automatic logic [26:0] exp_vec(int t, int glat);
    logic [26:0] v;
    v = '0;
    v[26]    = (tr[t].kind != 3);
    v[25]    = (tr[t].kind == 3);
    v[24:21] = 4'(tr[t].it);
    v[20]    = tr[t].rd;
    v[19]    = (tr[t].kind == 1) || (tr[t].kind == 2);
    v[17]    = tr[t].dr;
    v[16:11] = 6'(tr[t].st);
    v[10:9]  = 2'(tr[t].gp);
    if (t >= glat && tr[t-glat].rd) begin
      v[18]  = 1'b1;
      v[8]   = tr[t-glat].dr;
      v[7:2] = 6'(tr[t-glat].st);
      v[1:0] = 2'(tr[t-glat].gp);
    end
    return v;
  endfunction

  function automatic logic [26:0] exp_mask(int t, int glat);
    logic [26:0] m;
    m = M_HEAD;
    if (tr[t].rd) m = m | M_RD;
    if (t >= glat && tr[t-glat].rd) m = m | M_WR;
    return m;
  endfunction

  task automatic run_frame(input int s, input int pass_iter, input int maxd, input bit noise,
                           output int rd_cnt, output int wr_cnt, output int fin_iter,
                           output int chk_first);
    int g;
    int glat;
    logic [26:0] o, ev, m;
    g = (s == 1) ? 1 : 4;
    glat = (s == 1) ? 3 : 1;
    sel = s;
    rd_cnt = 0; wr_cnt = 0; fin_iter = -1; chk_first = -1;
    build(g, glat, pass_iter, maxd);
    @(negedge clk);
    start_d = 1'b1; abort_d = 1'b0; cv_d = 1'b0; cp_d = 1'b0;
    for (int t = 0; t < tr.size(); t++) begin
      @(negedge clk);
      start_d = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (tr[t].kind == 2) begin
        cv_d = 1'b1; cp_d = tr[t].cp;
      end else if (tr[t].kind == 1 || !noise) begin
        cv_d = 1'b0; cp_d = 1'($urandom_range(1, 0));
      end else begin
        cv_d = 1'($urandom_range(1, 0)); cp_d = 1'($urandom_range(1, 0));
      end
      o = (s == 1) ? obs_b : obs_a;
      ev = exp_vec(t, glat);
      m = exp_mask(t, glat);
      checks++;
      if ((o & m) !== (ev & m)) begin
        failures++;
        $display("FAIL frame_cycle sel=%0d t=%0d got=%h want=%h mask=%h", s, t, o & m, ev & m, m);
      end
      if (o[20]) rd_cnt++;
      if (o[18]) wr_cnt++;
      if (o[19] && chk_first < 0) chk_first = t;
      if (tr[t].kind == 3) fin_iter = int'(o[24:21]);
    end
    @(negedge clk);
    start_d = 1'b0; cv_d = 1'b0; cp_d = 1'b0;
    o = (s == 1) ? obs_b : obs_a;
    checks++;
    if ((o & M_CTRL) !== 27'h0) begin
      failures++;
      $display("FAIL frame_idle sel=%0d got=%h want=0", s, o & M_CTRL);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs_a !== 27'h0) begin failures++; $display("FAIL reset_a got=%h want=0", obs_a); end
    checks++;
    if (obs_b !== 27'h0) begin failures++; $display("FAIL reset_b got=%h want=0", obs_b); end
    rst = 1'b0;
  endtask

  task automatic test_first_pass();
    int rc, wc, fi, cf;
    run_frame(0, 0, 0, 1'b0, rc, wc, fi, cf);
    checks++;
    if (rc !== 48) begin failures++; $display("FAIL first_rd_count got=%0d want=48", rc); end
    checks++;
    if (wc !== 48) begin failures++; $display("FAIL first_wr_count got=%0d want=48", wc); end
    checks++;
    if (cf !== 60) begin failures++; $display("FAIL first_chk_cycle got=%0d want=61", cf + 1); end
    checks++;
    if (fi !== 0) begin failures++; $display("FAIL first_iter got=%0d want=0", fi); end
  endtask

  task automatic test_max_iter();
    int rc, wc, fi, cf;
    run_frame(0, MAX_ITER, 0, 1'b0, rc, wc, fi, cf);
    checks++;
    if (rc !== 720) begin failures++; $display("FAIL max_rd_count got=%0d want=720", rc); end
    checks++;
    if (wc !== 720) begin failures++; $display("FAIL max_wr_count got=%0d want=720", wc); end
    checks++;
    if (fi !== 14) begin failures++; $display("FAIL max_iter got=%0d want=14", fi); end
  endtask

  task automatic test_random_frames();
    int rc, wc, fi, cf, p, want_it;
    for (int n = 0; n < 3; n++) begin
      p = int'($urandom_range(MAX_ITER, 0));
      want_it = (p < MAX_ITER) ? p : MAX_ITER - 1;
      run_frame(0, p, 3, 1'b1, rc, wc, fi, cf);
      checks++;
      if (fi !== want_it) begin failures++; $display("FAIL rand_iter got=%0d want=%0d", fi, want_it); end
      checks++;
      if (rc !== 48 * (want_it + 1)) begin
        failures++; $display("FAIL rand_rd_count got=%0d want=%0d", rc, 48 * (want_it + 1));
      end
    end
  endtask

  task automatic test_abort();
    logic [26:0] o, ev, m;
    int ta;
    int rc, wc, fi, cf;
    ta = -1;
    sel = 0;
    build(4, 1, MAX_ITER, 0);
    for (int t = 0; t < tr.size(); t++)
      if (ta < 0 && tr[t].rd && tr[t].dr && tr[t].st == 2 && tr[t].gp == 1) ta = t;
    @(negedge clk);
    start_d = 1'b1;
    for (int t = 0; t <= ta; t++) begin
      @(negedge clk);
      start_d = 1'b0;
      o = obs_a; ev = exp_vec(t, 1); m = exp_mask(t, 1);
      checks++;
      if ((o & m) !== (ev & m)) begin
        failures++; $display("FAIL abort_pre t=%0d got=%h want=%h", t, o & m, ev & m);
      end
    end
    abort_d = 1'b1;
    @(negedge clk);
    abort_d = 1'b0;
    checks++;
    if ((obs_a & M_CTRL) !== 27'h0) begin
      failures++; $display("FAIL abort_next got=%h want=0", obs_a & M_CTRL);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ((obs_a & M_CTRL) !== 27'h0) begin
        failures++; $display("FAIL abort_quiet k=%0d got=%h want=0", k, obs_a & M_CTRL);
      end
    end
    run_frame(0, int'($urandom_range(3, 0)), 2, 1'b1, rc, wc, fi, cf);
  endtask

  task automatic test_start_abort_idle();
    sel = 0;
    @(negedge clk);
    start_d = 1'b1; abort_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_d = 1'b0; abort_d = 1'b0;
      checks++;
      if ((obs_a & M_CTRL) !== 27'h0) begin
        failures++; $display("FAIL start_abort_idle k=%0d got=%h want=0", k, obs_a & M_CTRL);
      end
    end
  endtask

  task automatic test_async_rst();
    sel = 0;
    @(negedge clk);
    start_d = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start_d = 1'b0;
    end
    checks++;
    if ((obs_a & 27'h4100000) !== 27'h4000000) begin
      failures++; $display("FAIL async_pre_bubble got=%h want=4000000", obs_a & 27'h4100000);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== 27'h0) begin failures++; $display("FAIL async_rst got=%h want=0", obs_a); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_glat3();
    int rc, wc, fi, cf;
    run_frame(1, 0, 0, 1'b0, rc, wc, fi, cf);
    checks++;
    if (rc !== 12) begin failures++; $display("FAIL glat3_rd_count got=%0d want=12", rc); end
    checks++;
    if (cf !== 48) begin failures++; $display("FAIL glat3_chk_cycle got=%0d want=48", cf); end
    run_frame(1, int'($urandom_range(4, 1)), 2, 1'b0, rc, wc, fi, cf);
    checks++;
    if (wc !== rc) begin failures++; $display("FAIL glat3_wr_count got=%0d want=%0d", wc, rc); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_max_iter();
    test_random_frames();
    test_abort();
    test_start_abort_idle();
    test_async_rst();
    test_glat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
